// File: rtl/pc_update_unit_if.sv
// Bus bundle for the PC update stage: control/datapath inputs and PC/EPC/status outputs.
// The slave modport is the pc_update_unit side; the master modport is the driver side.
interface pc_update_unit_if #(
    parameter int CAUSE_W = 2,
    parameter int CNT_W   = 16
);
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         branch_op;
    logic               zero;
    logic               neg;
    logic [2:0]         pc_src;
    logic [31:0]        alu_result;
    logic [31:0]        alu_out;
    logic [25:0]        jump_idx;
    logic [31:0]        mem_data;
    logic               exc_req;
    logic [CAUSE_W-1:0] exc_cause;
    logic [31:0]        pc;
    logic [31:0]        epc;
    logic [CAUSE_W-1:0] cause_q;
    logic               branch_taken;
    logic               exc_busy;
    logic [CNT_W-1:0]   taken_count;

    modport slave (
        input  pc_write, pc_write_cond, branch_op, zero, neg, pc_src,
               alu_result, alu_out, jump_idx, mem_data, exc_req, exc_cause,
        output pc, epc, cause_q, branch_taken, exc_busy, taken_count
    );

    modport master (
        output pc_write, pc_write_cond, branch_op, zero, neg, pc_src,
               alu_result, alu_out, jump_idx, mem_data, exc_req, exc_cause,
        input  pc, epc, cause_q, branch_taken, exc_busy, taken_count
    );
endinterface

// File: rtl/pc_update_unit.sv
// Multicycle PC stage: branch condition, PC write-enable, next-PC mux, EPC and exception redirect.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC,
    parameter int          CAUSE_W    = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    pc_update_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        REDIRECT
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               exc_busy_q, exc_busy_d;

    logic               cond;
    logic               branch_taken;
    logic               pc_en;
    logic [31:0]        next_pc;
    logic               next_valid;
    logic [31:0]        cause_ofs;

    always_comb begin
        cond = 1'b0;
        case (bus.branch_op)
            2'b00:   cond = bus.zero;
            2'b01:   cond = ~bus.zero;
            2'b10:   cond = bus.neg | bus.zero;
            default: cond = ~(bus.neg | bus.zero);
        endcase
    end

    assign branch_taken = bus.pc_write_cond & cond;
    assign pc_en        = bus.pc_write | branch_taken;

    // Sources 5-7 are reserved: PC holds even with pc_en asserted.
    always_comb begin
        next_pc    = pc_q;
        next_valid = 1'b1;
        case (bus.pc_src)
            3'd0:    next_pc = bus.alu_result;
            3'd1:    next_pc = bus.alu_out;
            3'd2:    next_pc = {pc_q[31:28], bus.jump_idx, 2'b00};
            3'd3:    next_pc = bus.mem_data;
            3'd4:    next_pc = epc_q;
            default: next_valid = 1'b0;
        endcase
    end

    assign cause_ofs = {{(30-CAUSE_W){1'b0}}, cause_q, 2'b00};

    // Outside IDLE all PC write requests and new exceptions are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (bus.exc_req) begin
                    state_d = SAVE;
                    cause_d = bus.exc_cause;
                end else if (pc_en && next_valid) begin
                    pc_d = next_pc;
                end
            end
            SAVE: begin
                epc_d   = pc_q - 32'd4;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_d    = EXC_VECTOR + cause_ofs;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        exc_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            cause_q    <= '0;
            exc_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            exc_busy_q <= exc_busy_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (branch_taken && (state_q == IDLE) && !bus.exc_req) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.taken_count = cnt_q;
`else
    assign bus.taken_count = {CNT_W{1'b0}};
`endif

    assign bus.pc           = pc_q;
    assign bus.epc          = epc_q;
    assign bus.cause_q      = cause_q;
    assign bus.branch_taken = branch_taken;
    assign bus.exc_busy     = exc_busy_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: vector table for branch/PC-source behaviour,
// hand-written sequences for exception redirect, async reset and the taken counter.
module tb_pc_update_unit;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    pc_update_unit_if #(.CAUSE_W(2), .CNT_W(16)) bus ();

    pc_update_unit #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_00FC),
        .CAUSE_W    (2),
        .CNT_W      (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  branch_op;
        logic        zero;
        logic        neg;
        logic        pwc;
        logic        pw;
        logic [2:0]  pc_src;
        logic [31:0] alu_result;
        logic [31:0] alu_out;
        logic [25:0] jump_idx;
        logic [31:0] mem_data;
        logic        exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_op     = 2'b00;
        bus.zero          = 1'b0;
        bus.neg           = 1'b0;
        bus.pc_src        = 3'd5;
        bus.alu_result    = '0;
        bus.alu_out       = '0;
        bus.jump_idx      = '0;
        bus.mem_data      = '0;
        bus.exc_req       = 1'b0;
        bus.exc_cause     = '0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        @(negedge clk);
        idle_inputs();
        bus.pc_write   = 1'b1;
        bus.pc_src     = 3'd0;
        bus.alu_result = v;
        @(posedge clk);
        #1;
        check("set_pc", bus.pc, v);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic branch(input logic [1:0] op, input logic z);
        @(negedge clk);
        idle_inputs();
        bus.pc_write_cond = 1'b1;
        bus.branch_op     = op;
        bus.zero          = z;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_cnt;

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();

        //            op    z     n     pwc   pw    src   alu_result     alu_out        jump_idx       mem_data       taken exp_pc
        vecs[0]  = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,         32'h40,        26'h0,         32'h0,         1'b1, 32'h0000_0040};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,         32'h80,        26'h0,         32'h0,         1'b0, 32'h0000_0040};
        vecs[2]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0,         32'h80,        26'h0,         32'h0,         1'b1, 32'h0000_0080};
        vecs[3]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0,         32'h90,        26'h0,         32'h0,         1'b0, 32'h0000_0080};
        vecs[4]  = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,         32'h90,        26'h0,         32'h0,         1'b0, 32'h0000_0080};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,         32'h90,        26'h0,         32'h0,         1'b1, 32'h0000_0090};
        vecs[6]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,         32'hA0,        26'h0,         32'h0,         1'b1, 32'h0000_00A0};
        vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'hA4,        32'h0,         26'h0,         32'h0,         1'b0, 32'h0000_00A4};
        vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h0,         32'h0,         26'h0,         32'hA000_0000, 1'b0, 32'hA000_0000};
        vecs[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h0,         32'h0,         26'h10,        32'h0,         1'b0, 32'hA000_0040};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 32'h1234,      32'h0,         26'h0,         32'h0,         1'b0, 32'hA000_0040};
        vecs[11] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'h1234,      32'h1234,      26'h0,         32'h0,         1'b1, 32'hA000_0040};
        vecs[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h55,        32'h0,         26'h0,         32'h0,         1'b0, 32'hA000_0040};
        vecs[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h104,       32'h0,         26'h0,         32'h0,         1'b0, 32'h0000_0104};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", bus.pc, 32'h0);
        check("reset_epc", bus.epc, 32'h0);
        check("reset_busy", {31'h0, bus.exc_busy}, 32'h0);
        check("reset_cause", {30'h0, bus.cause_q}, 32'h0);
        check("reset_count", {16'h0, bus.taken_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < 14; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.branch_op     = vecs[i].branch_op;
            bus.zero          = vecs[i].zero;
            bus.neg           = vecs[i].neg;
            bus.pc_write_cond = vecs[i].pwc;
            bus.pc_write      = vecs[i].pw;
            bus.pc_src        = vecs[i].pc_src;
            bus.alu_result    = vecs[i].alu_result;
            bus.alu_out       = vecs[i].alu_out;
            bus.jump_idx      = vecs[i].jump_idx;
            bus.mem_data      = vecs[i].mem_data;
            #1;
            check($sformatf("vec%0d_taken", i), {31'h0, bus.branch_taken}, {31'h0, vecs[i].exp_taken});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].exp_pc);
        end

        // Exception at pc=0x104, cause 2, colliding with a PC write.
        @(negedge clk);
        idle_inputs();
        bus.exc_req   = 1'b1;
        bus.exc_cause = 2'd2;
        bus.pc_write  = 1'b1;
        bus.pc_src    = 3'd1;
        bus.alu_out   = 32'h500;
        @(posedge clk);
        #1;
        check("exc_pc_suppressed", bus.pc, 32'h104);
        check("exc_busy_c1", {31'h0, bus.exc_busy}, 32'h1);
        check("exc_cause", {30'h0, bus.cause_q}, 32'h2);
        @(negedge clk);
        bus.exc_cause = 2'd3;
        bus.alu_out   = 32'h600;
        @(posedge clk);
        #1;
        check("exc_epc_save", bus.epc, 32'h100);
        check("exc_busy_c2", {31'h0, bus.exc_busy}, 32'h1);
        check("exc_pc_in_save", bus.pc, 32'h104);
        check("exc_cause_kept", {30'h0, bus.cause_q}, 32'h2);
        @(negedge clk);
        bus.exc_req = 1'b0;
        @(posedge clk);
        #1;
        check("exc_redirect_pc", bus.pc, 32'h104);
        check("exc_busy_end", {31'h0, bus.exc_busy}, 32'h0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("exc_not_queued", {31'h0, bus.exc_busy}, 32'h0);

        // Return from exception.
        @(negedge clk);
        idle_inputs();
        bus.pc_write = 1'b1;
        bus.pc_src   = 3'd4;
        @(posedge clk);
        #1;
        check("eret_pc", bus.pc, 32'h100);

        // EPC wrap: exception taken at pc=0 with cause 0.
        set_pc(32'h0);
        @(negedge clk);
        idle_inputs();
        bus.exc_req   = 1'b1;
        bus.exc_cause = 2'd0;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("epc_wrap", bus.epc, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("vector_cause0", bus.pc, 32'h0000_00FC);

        // Async reset in the middle of an exception sequence.
        @(negedge clk);
        bus.exc_req   = 1'b1;
        bus.exc_cause = 2'd1;
        @(posedge clk);
        #1;
        check("pre_reset_busy", {31'h0, bus.exc_busy}, 32'h1);
        idle_inputs();
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_pc", bus.pc, 32'h0);
        check("async_reset_epc", bus.epc, 32'h0);
        check("async_reset_busy", {31'h0, bus.exc_busy}, 32'h0);
        check("async_reset_cause", {30'h0, bus.cause_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Taken-branch counter: 3 taken, 2 not taken, PC held via reserved source.
        branch(2'b00, 1'b1);
        branch(2'b01, 1'b1);
        branch(2'b01, 1'b0);
        branch(2'b00, 1'b0);
        branch(2'b00, 1'b1);
        @(negedge clk);
        idle_inputs();
`ifdef BRANCH_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        check("count_3_taken", {16'h0, bus.taken_count}, {16'h0, exp_cnt});
        check("count_pc_held", bus.pc, 32'h0);

`ifdef BRANCH_STATS_EN
        @(negedge clk);
        bus.pc_write_cond = 1'b1;
        bus.branch_op     = 2'b00;
        bus.zero          = 1'b1;
        for (int unsigned k = 0; k < 65532; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.pc_write_cond = 1'b0;
        check("count_all_ones", {16'h0, bus.taken_count}, 32'h0000_FFFF);
        branch(2'b00, 1'b1);
        @(negedge clk);
        idle_inputs();
        check("count_wrap", {16'h0, bus.taken_count}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
